// File: rtl/prf_alloc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prf_alloc_ctrl_pkg
// Desc     : Shared constants, index types and FSM encoding for the PRF allocator.
// Revision : 1.0
// ============================================================================
package prf_alloc_ctrl_pkg;

  localparam int PRF_SIZE  = 48;
  localparam int ARF_SIZE  = 32;
  localparam int PRF_IDX_W = $clog2(PRF_SIZE);
  localparam int PRF_CNT_W = $clog2(PRF_SIZE + 1);

  typedef logic [PRF_IDX_W-1:0] prf_idx_t;
  typedef logic [PRF_CNT_W-1:0] prf_cnt_t;

  typedef enum logic [0:0] {
    ALLOC_NORMAL  = 1'b0,
    ALLOC_RECOVER = 1'b1
  } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/prf_alloc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : prf_alloc_ctrl_if
// Desc     : Rename-request, retire-free, bulk-free and status bundle for the allocator.
// Revision : 1.0
// ============================================================================
interface prf_alloc_ctrl_if #(
  parameter int PRF_SIZE = prf_alloc_ctrl_pkg::PRF_SIZE
);
  localparam int IDX_W = $clog2(PRF_SIZE);
  localparam int CNT_W = $clog2(PRF_SIZE + 1);

  logic                request1;
  logic                request2;
  logic                PRF_rename_valid1;
  logic [IDX_W-1:0]    PRF_rename_idx1;
  logic                PRF_rename_valid2;
  logic [IDX_W-1:0]    PRF_rename_idx2;
  logic                retire_free_valid1;
  logic [IDX_W-1:0]    retire_free_idx1;
  logic                retire_free_valid2;
  logic [IDX_W-1:0]    retire_free_idx2;
  logic                PRF_free_valid;
  logic [PRF_SIZE-1:0] PRF_free_list_in;
  logic                mispredict_sig;
  logic [CNT_W-1:0]    free_count;
  logic                alloc_halt;

  modport master (
    output request1, request2,
    output retire_free_valid1, retire_free_idx1,
    output retire_free_valid2, retire_free_idx2,
    output PRF_free_valid, PRF_free_list_in, mispredict_sig,
    input  PRF_rename_valid1, PRF_rename_idx1,
    input  PRF_rename_valid2, PRF_rename_idx2,
    input  free_count, alloc_halt
  );

  modport slave (
    input  request1, request2,
    input  retire_free_valid1, retire_free_idx1,
    input  retire_free_valid2, retire_free_idx2,
    input  PRF_free_valid, PRF_free_list_in, mispredict_sig,
    output PRF_rename_valid1, PRF_rename_idx1,
    output PRF_rename_valid2, PRF_rename_idx2,
    output free_count, alloc_halt
  );

endinterface
`default_nettype wire

// File: rtl/prf_alloc_ctrl_pick2.sv
`default_nettype none
// ============================================================================
// Module   : prf_pick2
// Desc     : Combinational finder for the lowest two set bits of a vector.
// Revision : 1.0
// ============================================================================
module prf_pick2 #(
  parameter int WIDTH = 48,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  wire logic [WIDTH-1:0] i_vec,
  output logic      [IDX_W-1:0] o_first_idx,
  output logic                  o_first_valid,
  output logic      [IDX_W-1:0] o_second_idx,
  output logic                  o_second_valid
);

  always_comb begin
    o_first_idx    = '0;
    o_first_valid  = 1'b0;
    o_second_idx   = '0;
    o_second_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        if (!o_first_valid) begin
          o_first_idx   = IDX_W'(i);
          o_first_valid = 1'b1;
        end else if (!o_second_valid) begin
          o_second_idx   = IDX_W'(i);
          o_second_valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prf_alloc_ctrl
// Desc     : 2-way rename PRF free-list allocator with retire/bulk reclaim and mispredict recovery.
// Revision : 1.0
// ============================================================================
module prf_alloc_ctrl #(
  parameter int PRF_SIZE = prf_alloc_ctrl_pkg::PRF_SIZE,
  parameter int ARF_SIZE = prf_alloc_ctrl_pkg::ARF_SIZE
) (
  input  wire logic       clock,
  input  wire logic       reset,
  prf_alloc_ctrl_if.slave bus
);
  import prf_alloc_ctrl_pkg::*;

  localparam int IDX_W = $clog2(PRF_SIZE);
  localparam int CNT_W = $clog2(PRF_SIZE + 1);

  localparam logic [PRF_SIZE-1:0] c_reset_list  = {PRF_SIZE{1'b1}} << ARF_SIZE;
  localparam logic [CNT_W-1:0]    c_reset_count = CNT_W'(PRF_SIZE - ARF_SIZE);

  logic [PRF_SIZE-1:0] r_free_list;
  logic [PRF_SIZE-1:0] w_free_list_next;
  logic [PRF_SIZE-1:0] w_alloc_mask;
  logic [PRF_SIZE-1:0] w_free_mask;
  logic [CNT_W-1:0]    r_free_count;
  logic [CNT_W-1:0]    w_free_count_next;
  alloc_state_t        r_state;
  alloc_state_t        w_state_next;

  logic [IDX_W-1:0]    w_l0;
  logic [IDX_W-1:0]    w_l1;
  logic                w_l0_valid;
  logic                w_l1_valid;
  logic                w_grant_en;
  logic                w_valid1;
  logic                w_valid2;
  logic [IDX_W-1:0]    w_idx1;
  logic [IDX_W-1:0]    w_idx2;

  prf_pick2 #(
    .WIDTH (PRF_SIZE),
    .IDX_W (IDX_W)
  ) u_pick2 (
    .i_vec          (r_free_list),
    .o_first_idx    (w_l0),
    .o_first_valid  (w_l0_valid),
    .o_second_idx   (w_l1),
    .o_second_valid (w_l1_valid)
  );

  // Grants are only offered in NORMAL on a cycle without a fresh mispredict.
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    case (r_state)
      ALLOC_NORMAL: begin
        w_grant_en = !bus.mispredict_sig;
        if (bus.mispredict_sig) w_state_next = ALLOC_RECOVER;
      end
      ALLOC_RECOVER: begin
        w_state_next = bus.mispredict_sig ? ALLOC_RECOVER : ALLOC_NORMAL;
      end
      default: w_state_next = ALLOC_NORMAL;
    endcase
  end

  // Slot 2 takes L1 only when slot 1 also asks; L1 valid implies L0 valid, which keeps grants in order.
  always_comb begin
    w_valid1 = 1'b0;
    w_idx1   = '0;
    w_valid2 = 1'b0;
    w_idx2   = '0;
    if (reset && w_grant_en) begin
      if (bus.request1 && w_l0_valid) begin
        w_valid1 = 1'b1;
        w_idx1   = w_l0;
      end
      if (bus.request2) begin
        if (bus.request1) begin
          if (w_l1_valid) begin
            w_valid2 = 1'b1;
            w_idx2   = w_l1;
          end
        end else if (w_l0_valid) begin
          w_valid2 = 1'b1;
          w_idx2   = w_l0;
        end
      end
    end
  end

  always_comb begin
    w_alloc_mask = '0;
    w_free_mask  = bus.PRF_free_valid ? bus.PRF_free_list_in : '0;
    for (int i = 0; i < PRF_SIZE; i++) begin
      if ((w_valid1 && (w_idx1 == IDX_W'(i))) || (w_valid2 && (w_idx2 == IDX_W'(i))))
        w_alloc_mask[i] = 1'b1;
      if ((bus.retire_free_valid1 && (bus.retire_free_idx1 == IDX_W'(i))) ||
          (bus.retire_free_valid2 && (bus.retire_free_idx2 == IDX_W'(i))))
        w_free_mask[i] = 1'b1;
    end
    // Allocated entries are already free, so a coincident free of them is a no-op and must not undo the allocation.
    w_free_list_next  = (r_free_list | w_free_mask) & ~w_alloc_mask;
    w_free_count_next = '0;
    for (int i = 0; i < PRF_SIZE; i++) begin
      w_free_count_next = w_free_count_next + CNT_W'(w_free_list_next[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_free_list  <= c_reset_list;
      r_free_count <= c_reset_count;
      r_state      <= ALLOC_NORMAL;
    end else begin
      r_free_list  <= w_free_list_next;
      r_free_count <= w_free_count_next;
      r_state      <= w_state_next;
    end
  end

  assign bus.PRF_rename_valid1 = w_valid1;
  assign bus.PRF_rename_idx1   = w_idx1;
  assign bus.PRF_rename_valid2 = w_valid2;
  assign bus.PRF_rename_idx2   = w_idx2;
  assign bus.free_count        = r_free_count;
  assign bus.alloc_halt        = reset && ((bus.request1 && !w_valid1) || (bus.request2 && !w_valid2));

endmodule
`default_nettype wire

// File: tb/tb_prf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_alloc_ctrl
// Desc     : Scoreboard bench for prf_alloc_ctrl with directed scenarios and random traffic.
// Revision : 1.0
// ============================================================================
module tb_prf_alloc_ctrl;
  import prf_alloc_ctrl_pkg::*;

  logic clock;
  logic reset;

  prf_alloc_ctrl_if bus ();

  prf_alloc_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic v1;
    int   i1;
    logic v2;
    int   i2;
    logic halt;
    int   cnt;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] mdl_free;
  logic        mdl_recover;
  logic [47:0] pend_free;
  logic        pend_recover;
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [47:0] c_init_list = {16'hFFFF, 32'h0};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Applies one cycle of inputs and pushes the reference outcome for the monitor.
  task automatic drive(input logic r1, input logic r2,
                       input logic rv1, input int ri1,
                       input logic rv2, input int ri2,
                       input logic fv, input logic [47:0] fl,
                       input logic misp);
    exp_t        e;
    int          l0;
    int          l1;
    logic        en;
    logic [47:0] fmask;
    logic [47:0] amask;
    bus.request1           = r1;
    bus.request2           = r2;
    bus.retire_free_valid1 = rv1;
    bus.retire_free_idx1   = prf_idx_t'(ri1);
    bus.retire_free_valid2 = rv2;
    bus.retire_free_idx2   = prf_idx_t'(ri2);
    bus.PRF_free_valid     = fv;
    bus.PRF_free_list_in   = fl;
    bus.mispredict_sig     = misp;
    l0 = -1;
    l1 = -1;
    for (int i = 0; i < 48; i++) begin
      if (mdl_free[i]) begin
        if (l0 < 0) l0 = i;
        else if (l1 < 0) l1 = i;
      end
    end
    en   = !mdl_recover && !misp;
    e.v1 = en && r1 && (l0 >= 0);
    e.i1 = e.v1 ? l0 : 0;
    e.v2 = 1'b0;
    e.i2 = 0;
    if (r1 && r2) begin
      e.v2 = en && (l1 >= 0);
      e.i2 = e.v2 ? l1 : 0;
    end else if (r2) begin
      e.v2 = en && (l0 >= 0);
      e.i2 = e.v2 ? l0 : 0;
    end
    e.halt = (r1 && !e.v1) || (r2 && !e.v2);
    e.cnt  = $countones(mdl_free);
    sb.push_back(e);
    fmask = fv ? fl : 48'h0;
    if (rv1 && ri1 < 48) fmask[ri1] = 1'b1;
    if (rv2 && ri2 < 48) fmask[ri2] = 1'b1;
    amask = 48'h0;
    if (e.v1) amask[e.i1] = 1'b1;
    if (e.v2) amask[e.i2] = 1'b1;
    pend_free    = (mdl_free | fmask) & ~amask;
    pend_recover = misp;
  endtask

  task automatic req(input logic r1, input logic r2);
    drive(r1, r2, 1'b0, 0, 1'b0, 0, 1'b0, 48'h0, 1'b0);
  endtask

  task automatic advance();
    @(posedge clock);
    mdl_free    = pend_free;
    mdl_recover = pend_recover;
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_valid1",     int'(bus.PRF_rename_valid1), int'(e.v1));
      check("sb_idx1",       int'(bus.PRF_rename_idx1),   e.i1);
      check("sb_valid2",     int'(bus.PRF_rename_valid2), int'(e.v2));
      check("sb_idx2",       int'(bus.PRF_rename_idx2),   e.i2);
      check("sb_halt",       int'(bus.alloc_halt),        int'(e.halt));
      check("sb_free_count", int'(bus.free_count),        e.cnt);
    end
  end

  initial begin
    logic [47:0] rnd_mask;
    reset       = 1'b0;
    mdl_free    = c_init_list;
    mdl_recover = 1'b0;
    pend_free   = c_init_list;
    pend_recover = 1'b0;
    bus.request1 = 1'b0; bus.request2 = 1'b0;
    bus.retire_free_valid1 = 1'b0; bus.retire_free_idx1 = '0;
    bus.retire_free_valid2 = 1'b0; bus.retire_free_idx2 = '0;
    bus.PRF_free_valid = 1'b0; bus.PRF_free_list_in = '0;
    bus.mispredict_sig = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid1", int'(bus.PRF_rename_valid1), 0);
    check("rst_valid2", int'(bus.PRF_rename_valid2), 0);
    check("rst_halt",   int'(bus.alloc_halt), 0);
    check("rst_count",  int'(bus.free_count), 16);
    reset = 1'b1;

    // Fresh list: both slots take the first two free entries.
    req(1, 1); @(negedge clock);
    check("t1_idx1", int'(bus.PRF_rename_idx1), 32);
    check("t1_idx2", int'(bus.PRF_rename_idx2), 33);
    check("t1_halt", int'(bus.alloc_halt), 0);
    advance();
    req(0, 0); @(negedge clock);
    check("t1_count", int'(bus.free_count), 14);
    advance();

    // Drain down to entry 47 alone.
    repeat (6) begin req(1, 1); advance(); end
    req(1, 0); advance();
    req(1, 1); @(negedge clock);
    check("t2_valid1", int'(bus.PRF_rename_valid1), 1);
    check("t2_idx1",   int'(bus.PRF_rename_idx1), 47);
    check("t2_valid2", int'(bus.PRF_rename_valid2), 0);
    check("t2_halt",   int'(bus.alloc_halt), 1);
    advance();
    req(1, 0); @(negedge clock);
    check("t2_empty_halt",  int'(bus.alloc_halt), 1);
    check("t2_empty_count", int'(bus.free_count), 0);
    advance();

    // Retire frees are not bypassed to same-cycle requests.
    drive(1, 1, 1, 12, 1, 3, 0, 48'h0, 0); @(negedge clock);
    check("t3_nobypass", int'(bus.PRF_rename_valid1), 0);
    advance();
    req(1, 1); @(negedge clock);
    check("t3_idx1", int'(bus.PRF_rename_idx1), 3);
    check("t3_idx2", int'(bus.PRF_rename_idx2), 12);
    advance();

    // Mispredict with bulk free of 10 and 12: two dead cycles, then grants.
    drive(1, 1, 0, 0, 0, 0, 1, (48'h1 << 10) | (48'h1 << 12), 1); @(negedge clock);
    check("t4_misp_v1", int'(bus.PRF_rename_valid1), 0);
    check("t4_misp_v2", int'(bus.PRF_rename_valid2), 0);
    advance();
    req(1, 1); @(negedge clock);
    check("t4_recover_v1", int'(bus.PRF_rename_valid1), 0);
    check("t4_recover_halt", int'(bus.alloc_halt), 1);
    check("t4_count_up", int'(bus.free_count), 2);
    advance();
    req(1, 1); @(negedge clock);
    check("t4_idx1", int'(bus.PRF_rename_idx1), 10);
    check("t4_idx2", int'(bus.PRF_rename_idx2), 12);
    advance();
    req(0, 0); @(negedge clock);
    check("t4_count_down", int'(bus.free_count), 0);
    advance();

    // Duplicate frees count once.
    drive(0, 0, 1, 40, 0, 0, 0, 48'h0, 0); advance();
    drive(0, 0, 1, 40, 1, 40, 0, 48'h0, 0); @(negedge clock);
    check("t5_count_once", int'(bus.free_count), 1);
    advance();
    drive(0, 0, 1, 41, 1, 41, 0, 48'h0, 0); @(negedge clock);
    check("t5_refree_count", int'(bus.free_count), 1);
    advance();
    req(0, 0); @(negedge clock);
    check("t5_dual_port_count", int'(bus.free_count), 2);
    advance();

    // Random traffic against the reference model.
    repeat (300) begin
      rnd_mask = {16'($urandom), 32'($urandom)} & {16'($urandom), 32'($urandom)} &
                 {16'($urandom), 32'($urandom)};
      drive(1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 47)),
            1'($urandom), int'($urandom_range(0, 47)),
            ($urandom_range(0, 7) == 0), rnd_mask,
            ($urandom_range(0, 15) == 0));
      advance();
    end

    // Mid-cycle reset with requests held.
    drive(1, 1, 1, 5, 1, 6, 0, 48'h0, 0); @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_valid1", int'(bus.PRF_rename_valid1), 0);
    check("t6_valid2", int'(bus.PRF_rename_valid2), 0);
    check("t6_idx1",   int'(bus.PRF_rename_idx1), 0);
    check("t6_halt",   int'(bus.alloc_halt), 0);
    check("t6_count",  int'(bus.free_count), 16);
    mdl_free    = c_init_list;
    mdl_recover = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    req(1, 0); @(negedge clock);
    check("t6_first_grant", int'(bus.PRF_rename_idx1), 32);
    check("t6_post_count",  int'(bus.free_count), 16);
    advance();
    req(0, 0); @(negedge clock);
    advance();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prf_alloc_ctrl.md
Name: prf_alloc_ctrl

Overview:
- Physical-register allocator/arbiter for the 2-way rename stage.
- Owns the PRF free list and serves two in-order rename requesters (slot 1 older than slot 2) each cycle, returning the PRF index that the RAT writes into its dest mapping.
- Reclaims entries from two ROB retire ports and from the RAT bulk-free vector on mispredict.
- Sequences a one-cycle recovery window after mispredict.

Parameters:
- PRF_SIZE, 48, number of physical registers.
- ARF_SIZE, 32, number of architectural registers. Entries 0..ARF_SIZE-1 are busy at reset (initial mapping).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- request1  in  1  slot-1 rename needs a dest PRF.
- request2  in  1  slot-2 rename needs a dest PRF.
- PRF_rename_valid1  out  1  slot-1 grant.
- PRF_rename_idx1  out  $clog2(PRF_SIZE)  slot-1 granted index.
- PRF_rename_valid2  out  1  slot-2 grant.
- PRF_rename_idx2  out  $clog2(PRF_SIZE)  slot-2 granted index.
- retire_free_valid1  in  1  ROB commit frees an old mapping.
- retire_free_idx1  in  $clog2(PRF_SIZE)  index freed by retire port 1.
- retire_free_valid2  in  1  ROB commit frees an old mapping.
- retire_free_idx2  in  $clog2(PRF_SIZE)  index freed by retire port 2.
- PRF_free_valid  in  1  RAT bulk-free vector is valid.
- PRF_free_list_in  in  PRF_SIZE  one-hot-per-entry bulk free from the RAT.
- mispredict_sig  in  1  branch mispredict flush.
- free_count  out  $clog2(PRF_SIZE+1)  number of free entries (registered).
- alloc_halt  out  1  some request in this cycle was not granted.

Behaviour:
- State: free_list[PRF_SIZE] register (1 = free), free_count register, FSM {NORMAL, RECOVER}.
- Reset (async, reset=0):
  - free_list = entries ARF_SIZE..PRF_SIZE-1 free; free_count = PRF_SIZE-ARF_SIZE; FSM = NORMAL.
  - All grant outputs 0, idx outputs 0, alloc_halt 0.
  - Reset asserted mid-operation discards all pending grants and frees immediately.
- Grants are combinational from the current free_list, so a request is answered in the same cycle. Allocation commits at posedge (entry becomes busy).
- Selection:
  - Lowest free index is L0; second-lowest is L1.
  - request1 alone gets L0.
  - request2 alone gets L0.
  - Both requests: slot 1 gets L0, slot 2 gets L1.
- In-order rule: slot 2 is never granted while a requested slot 1 is denied.
  - 1 free entry with both requests: slot 1 granted, slot 2 denied, alloc_halt=1.
  - 0 free entries: no grant, alloc_halt=1 if any request is asserted.
- Ungranted slots drive idx=0, valid=0.
- Frees: retire ports and PRF_free_list_in (when PRF_free_valid) are ORed into free_list at posedge. A freed entry becomes allocatable the following cycle; there is no same-cycle bypass.
- Freeing an already-free entry is harmless: no double count. Two retire ports carrying the same idx count once.
- free_count_next = popcount(free_list_next). The invariant free_count == popcount(free_list) holds every cycle.
- FSM:
  - NORMAL + mispredict_sig=1: all grants suppressed this cycle, frees still applied, go to RECOVER.
  - RECOVER: all grants suppressed, alloc_halt=1 if any request is asserted, then go to NORMAL.
  - mispredict_sig=1 while in RECOVER: stay in RECOVER one more cycle.
- Index 0 is allocatable once freed; it is not reserved.

Decomposition:
- Shared package: PRF_SIZE/ARF_SIZE constants, the prf_idx_t typedef ($clog2(PRF_SIZE) bits), and the alloc FSM state enum.
- One sub-module, prf_pick2: a combinational finder returning the lowest two set bits of a vector plus their valid flags. It is reused by future issue selection.

Test Plan (PRF_SIZE=48, ARF_SIZE=32):
1. Reset release, then both requests → idx1=32, idx2=33, both valid, halt=0. Next cycle free_count=14.
2. Drain to 1 free entry (47), then both requests → valid1=1, idx1=47, valid2=0, alloc_halt=1. Next cycle free_count=0 and a single request yields halt=1.
3. With the list empty, retire_free idx 12 and 3 in the same cycle → no grant that cycle. Next cycle both requests get idx1=3, idx2=12.
4. mispredict_sig=1 with PRF_free_valid=1, PRF_free_list_in bits {10,12} set while both are busy, and requests asserted → no grants for 2 cycles (mispredict + RECOVER). Third cycle grants idx 10, 12; free_count goes up by 2 then down by 2.
5. Retire frees an already-free index 40 → free_count unchanged, and the invariant check passes.
6. Assert reset mid-stream with requests asserted → outputs 0 asynchronously. After release, free_count=16 and the first grant is 32.
